// File: rtl/bsg_manycore_rocc_pkg.sv
// rtl/bsg_manycore_rocc_pkg.sv - shared types and store-piece selection for the manycore-to-Rocket bridge
package bsg_manycore_rocc_pkg;

  typedef enum logic [2:0] {
    eRoCC_mem_8bits  = 3'd0,
    eRoCC_mem_16bits = 3'd1,
    eRoCC_mem_32bits = 3'd2,
    eRoCC_mem_64bits = 3'd3
  } bsg_rocc_mem_size_e;

  typedef enum logic {
    eIdle,
    eIssue
  } bsg_rocc_bridge_state_e;

  // One Rocket store request carved out of a manycore byte mask.
  typedef struct packed {
    bsg_rocc_mem_size_e typ;
    logic [2:0]         offset;
    logic [7:0]         lanes;
  } bsg_rocc_mem_piece_s;

  // An exact naturally aligned power-of-two group (full width included) goes out as one
  // store; anything else goes out as a byte store of the lowest set lane.
  function automatic bsg_rocc_mem_piece_s pick_piece(input logic [7:0] mask, input int lg_bytes);
    bsg_rocc_mem_piece_s p;
    logic [7:0] grp;
    p.typ    = eRoCC_mem_8bits;
    p.offset = 3'd0;
    p.lanes  = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        p.offset = 3'(i);
        p.lanes  = 8'd1 << i;
      end
    end
    for (int k = 1; k <= 3; k++) begin
      for (int o = 0; o < 8; o += (1 << k)) begin
        grp = 8'(((1 << (1 << k)) - 1) << o);
        if (k <= lg_bytes && mask == grp) begin
          p.typ    = bsg_rocc_mem_size_e'(3'(k));
          p.offset = 3'(o);
          p.lanes  = grp;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bsg_manycore_rocc_tag_alloc.sv
// rtl/bsg_manycore_rocc_tag_alloc.sv - free-tag bitmap with lowest-free allocation and in-flight count
module bsg_manycore_rocc_tag_alloc
  #(parameter int els_p = 4
  , localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1
  , localparam int count_width_lp = $clog2(els_p + 1))
  (input  logic                      clk_i
  , input  logic                      reset_n_i
  , input  logic                      alloc_i
  , input  logic                      free_v_i
  , input  logic [tag_width_lp-1:0]   free_tag_i
  , output logic                      avail_o
  , output logic [tag_width_lp-1:0]   alloc_tag_o
  , output logic [count_width_lp-1:0] count_o
  , output logic                      illegal_free_o
  );

  logic [els_p-1:0] free_r, alloc_bit, free_bit;
  logic [(1 << tag_width_lp)-1:0] free_ext;
  logic [count_width_lp-1:0] count_r;
  logic alloc_fire, free_ok;

  always_comb begin
    alloc_tag_o = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (free_r[i]) alloc_tag_o = tag_width_lp'(i);
    end
  end

  // Tag codes beyond els_p read as already free, so freeing them is flagged illegal.
  always_comb begin
    free_ext = '1;
    free_ext[els_p-1:0] = free_r;
  end

  assign avail_o        = |free_r;
  assign alloc_fire     = alloc_i & avail_o;
  assign free_ok        = free_v_i & ~free_ext[free_tag_i];
  assign illegal_free_o = free_v_i & ~free_ok;
  assign alloc_bit      = alloc_fire ? (els_p'(1) << alloc_tag_o) : '0;
  assign free_bit       = free_ok ? (els_p'(1) << free_tag_i) : '0;
  assign count_o        = count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      free_r  <= '1;
      count_r <= '0;
    end else begin
      free_r  <= (free_r & ~alloc_bit) | free_bit;
      count_r <= count_r + count_width_lp'(alloc_fire) - count_width_lp'(free_ok);
    end
  end

endmodule

// File: rtl/bsg_manycore_rocc_mem_bridge.sv
// rtl/bsg_manycore_rocc_mem_bridge.sv - tags manycore remote stores and issues them as legal Rocket stores
module bsg_manycore_rocc_mem_bridge
  import bsg_manycore_rocc_pkg::*;
  #(parameter int addr_width_p      = 26
  , parameter int data_width_p      = 32
  , parameter int rocc_addr_width_p = 40
  , parameter int rocc_data_width_p = 64
  , parameter int max_outstanding_p = 4
  , localparam int tag_width_lp   = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
  , localparam int lg_bytes_lp    = $clog2(data_width_p / 8)
  , localparam int seg_width_lp   = rocc_addr_width_p - addr_width_p - lg_bytes_lp
  , localparam int mask_width_lp  = data_width_p / 8
  , localparam int count_width_lp = $clog2(max_outstanding_p + 1))
  (input  logic                         clk_i
  , input  logic                         reset_n_i
  , input  logic                         in_v_i
  , input  logic [addr_width_p-1:0]      in_addr_i
  , input  logic [data_width_p-1:0]      in_data_i
  , input  logic [mask_width_lp-1:0]     in_mask_i
  , output logic                         in_yumi_o
  , input  logic                         seg_v_i
  , input  logic [seg_width_lp-1:0]      seg_addr_i
  , output logic                         mem_req_v_o
  , output logic [rocc_addr_width_p-1:0] mem_req_addr_o
  , output logic [tag_width_lp-1:0]      mem_req_tag_o
  , output logic [2:0]                   mem_req_typ_o
  , output logic [rocc_data_width_p-1:0] mem_req_data_o
  , input  logic                         mem_req_ready_i
  , input  logic                         mem_resp_v_i
  , input  logic [tag_width_lp-1:0]      mem_resp_tag_i
  , input  logic                         fence_i
  , output logic                         fence_done_o
  , output logic                         busy_o
  , output logic [count_width_lp-1:0]    outstanding_o
  , output logic                         err_o
  );

  bsg_rocc_bridge_state_e state_r, state_n;
  logic [seg_width_lp-1:0]  seg_r;
  logic [addr_width_p-1:0]  addr_r;
  logic [data_width_p-1:0]  data_r, lane_bits;
  logic [mask_width_lp-1:0] rem_mask_r, rem_mask_next;
  bsg_rocc_mem_piece_s piece;
  logic tag_avail, hs, last_hs, illegal_free, err_r;
  logic unused_piece_bits;

  bsg_manycore_rocc_tag_alloc #(.els_p(max_outstanding_p)) tags (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .alloc_i        (hs),
    .free_v_i       (mem_resp_v_i),
    .free_tag_i     (mem_resp_tag_i),
    .avail_o        (tag_avail),
    .alloc_tag_o    (mem_req_tag_o),
    .count_o        (outstanding_o),
    .illegal_free_o (illegal_free)
  );

  assign piece         = pick_piece(8'(rem_mask_r), lg_bytes_lp);
  assign rem_mask_next = rem_mask_r & ~piece.lanes[mask_width_lp-1:0];
  assign unused_piece_bits = ^{piece.offset, piece.lanes};

  assign mem_req_v_o = (state_r == eIssue) & tag_avail;
  assign hs          = mem_req_v_o & mem_req_ready_i;
  assign last_hs     = hs & (rem_mask_next == '0);
  // Accepting while the last piece leaves keeps back-to-back stores at one piece per cycle.
  assign in_yumi_o   = in_v_i & ~fence_i & ((state_r == eIdle) | last_hs);

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < mask_width_lp; i++) lane_bits[8*i +: 8] = {8{piece.lanes[i]}};
  end

  assign mem_req_addr_o = {seg_r, addr_r, piece.offset[lg_bytes_lp-1:0]};
  assign mem_req_typ_o  = piece.typ;
  assign mem_req_data_o = rocc_data_width_p'((data_r & lane_bits) >> {piece.offset[lg_bytes_lp-1:0], 3'b000});

  assign err_o        = err_r;
  assign busy_o       = (state_r != eIdle) | (outstanding_o != '0);
  assign fence_done_o = fence_i & (state_r == eIdle) & (outstanding_o == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eIdle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eIdle:   if (in_yumi_o && in_mask_i != '0) state_n = eIssue;
      eIssue:  if (last_hs) state_n = (in_yumi_o && in_mask_i != '0) ? eIssue : eIdle;
      default: state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      seg_r      <= '0;
      addr_r     <= '0;
      data_r     <= '0;
      rem_mask_r <= '0;
      err_r      <= 1'b0;
    end else begin
      if (seg_v_i) seg_r <= seg_addr_i;
      if (in_yumi_o) begin
        addr_r     <= in_addr_i;
        data_r     <= in_data_i;
        rem_mask_r <= in_mask_i;
      end else if (hs) begin
        rem_mask_r <= rem_mask_next;
      end
      if (illegal_free) err_r <= 1'b1;
    end
  end

endmodule
